// File: rtl/tlp_rp_fifo_pkg.sv
// Shared TLP word layout and header codes for the root-port receive FIFO.
// Word: [127:96] DW3, [95:64] DW2, [63:32] DW1, [31:0] DW0, plus framing flags above.
package tlp_rp_fifo_pkg;

  localparam int TLP_W     = 131;
  localparam int SOP_BIT   = 128;
  localparam int EOP_BIT   = 129;
  localparam int EMPTY_BIT = 130;

  localparam logic [1:0] FMT_MRD_3DW = 2'b00;
  localparam logic [1:0] FMT_MRD_4DW = 2'b01;
  localparam logic [1:0] FMT_MWR_3DW = 2'b10;
  localparam logic [4:0] TYPE_MEM    = 5'b00000;

  function automatic logic isMRd(input logic [1:0] fmt, input logic [4:0] typ);
    return ((fmt == FMT_MRD_3DW) || (fmt == FMT_MRD_4DW)) && (typ == TYPE_MEM);
  endfunction

  function automatic logic isMWr3dw(input logic [1:0] fmt, input logic [4:0] typ);
    return (fmt == FMT_MWR_3DW) && (typ == TYPE_MEM);
  endfunction

endpackage

// File: rtl/tlp_sync_fifo.sv
// Single-clock show-ahead FIFO; enables arrive already qualified against full/empty.
module tlp_sync_fifo #(
  parameter int WIDTH = 131,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wrData,
  input  logic             wrEn,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr[AW-1:0]] <= wrData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PTR_ONE;
      if (rdEn) rdPtr <= rdPtr + PTR_ONE;
    end
  end

  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty  = (wrPtr == rdPtr);
  assign rdData = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/tlp_rp_fifo.sv
// Root-port TLP FIFO with TLP/read tracking and a snooped mailbox IRQ-enable register.
module tlp_rp_fifo
  import tlp_rp_fifo_pkg::*;
#(
  parameter int          DEPTH       = 32,
  parameter int          MAX_RD      = 8,
  parameter logic [31:0] MB_BASE     = 32'h0000_1000,
  parameter logic [11:0] IRQ_ENA_OFS = 12'h050
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TLP_W-1:0] RxRpFifoWrData,
  input  logic             RxRpFifoWrReq,
  output logic             RxRpFifoFull,
  output logic [TLP_W-1:0] TxRpFifoData,
  input  logic             TxRpFifoRdReq,
  output logic             RpTLPReady,
  output logic             RxRdInProgress,
  input  logic             RxCplDone,
  output logic [11:0]      A2PMbWrAddr,
  output logic             A2PMbWrReq,
  output logic [31:0]      PCIeIrqEna,
  input  logic             CfgBusMstrEn,
  output logic             MasterEnable,
  output logic             OverflowErr
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(MAX_RD + 1);
  localparam logic [AW:0]   TLP_ONE = 1;
  localparam logic [RW-1:0] RD_ONE  = 1;
  localparam logic [RW-1:0] RD_SAT  = RW'(MAX_RD);

  logic          fifoFull;
  logic          fifoEmpty;
  logic          push;
  logic          pop;
  logic          pushEop;
  logic          popEop;
  logic          mrdPop;
  logic          mbHit;
  logic [AW:0]   tlpCnt;
  logic [RW-1:0] rdCnt;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pop  = TxRpFifoRdReq && !fifoEmpty;
  assign push = RxRpFifoWrReq && (!fifoFull || pop);

  tlp_sync_fifo #(.WIDTH(TLP_W), .DEPTH(DEPTH)) uFifo (
    .clk    (clk),
    .rst    (rst),
    .wrData (RxRpFifoWrData),
    .wrEn   (push),
    .rdEn   (pop),
    .rdData (TxRpFifoData),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  assign pushEop = push && RxRpFifoWrData[EOP_BIT];
  assign popEop  = pop && TxRpFifoData[EOP_BIT];
  assign mrdPop  = pop && TxRpFifoData[SOP_BIT] && isMRd(TxRpFifoData[30:29], TxRpFifoData[28:24]);
  assign mbHit   = push && RxRpFifoWrData[SOP_BIT]
                   && isMWr3dw(RxRpFifoWrData[30:29], RxRpFifoWrData[28:24])
                   && (RxRpFifoWrData[95:76] == MB_BASE[31:12]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tlpCnt       <= '0;
      rdCnt        <= '0;
      OverflowErr  <= 1'b0;
      MasterEnable <= 1'b0;
    end else begin
      if (pushEop && !popEop)      tlpCnt <= tlpCnt + TLP_ONE;
      else if (!pushEop && popEop) tlpCnt <= tlpCnt - TLP_ONE;
      if (mrdPop && !RxCplDone && (rdCnt != RD_SAT))  rdCnt <= rdCnt + RD_ONE;
      else if (!mrdPop && RxCplDone && (rdCnt != '0)) rdCnt <= rdCnt - RD_ONE;
      if (RxRpFifoWrReq && !push) OverflowErr <= 1'b1;
      MasterEnable <= CfgBusMstrEn;
    end
  end

  // Mailbox stage: strobe and register update one cycle after the header is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A2PMbWrReq  <= 1'b0;
      A2PMbWrAddr <= '0;
      PCIeIrqEna  <= '0;
    end else begin
      A2PMbWrReq <= mbHit;
      if (mbHit) begin
        A2PMbWrAddr <= RxRpFifoWrData[75:64];
        if (RxRpFifoWrData[75:64] == IRQ_ENA_OFS) PCIeIrqEna <= RxRpFifoWrData[127:96];
      end
    end
  end

  assign RxRpFifoFull   = fifoFull;
  assign RpTLPReady     = (tlpCnt != '0);
  assign RxRdInProgress = (rdCnt != '0);

endmodule

// File: tb/tb_tlp_rp_fifo.sv
// Directed bench for tlp_rp_fifo: scoreboard queue of pushed words checked on every pop.
module tb_tlp_rp_fifo;
  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [130:0] RxRpFifoWrData = '0;
  logic         RxRpFifoWrReq = 1'b0;
  logic         RxRpFifoFull;
  logic [130:0] TxRpFifoData;
  logic         TxRpFifoRdReq = 1'b0;
  logic         RpTLPReady;
  logic         RxRdInProgress;
  logic         RxCplDone = 1'b0;
  logic [11:0]  A2PMbWrAddr;
  logic         A2PMbWrReq;
  logic [31:0]  PCIeIrqEna;
  logic         CfgBusMstrEn = 1'b0;
  logic         MasterEnable;
  logic         OverflowErr;

  int total = 0;
  int bad = 0;
  logic [130:0] sb[$];

  tlp_rp_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .RxRpFifoWrData(RxRpFifoWrData), .RxRpFifoWrReq(RxRpFifoWrReq), .RxRpFifoFull(RxRpFifoFull),
    .TxRpFifoData(TxRpFifoData), .TxRpFifoRdReq(TxRpFifoRdReq), .RpTLPReady(RpTLPReady),
    .RxRdInProgress(RxRdInProgress), .RxCplDone(RxCplDone), .A2PMbWrAddr(A2PMbWrAddr),
    .A2PMbWrReq(A2PMbWrReq), .PCIeIrqEna(PCIeIrqEna), .CfgBusMstrEn(CfgBusMstrEn),
    .MasterEnable(MasterEnable), .OverflowErr(OverflowErr)
  );

  always #5 clk = ~clk;

  function automatic logic [130:0] mkWord(input logic sop, input logic eop, input logic [31:0] dw0,
                                          input logic [31:0] addr, input logic [31:0] data);
    return {1'b0, eop, sop, data, addr, 32'h0, dw0};
  endfunction

  task automatic check(input string tag, input logic [130:0] obs, input logic [130:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [130:0] w);
    RxRpFifoWrData = w;
    RxRpFifoWrReq  = 1'b1;
    if (sb.size() < DEPTH) sb.push_back(w);
    tick();
    RxRpFifoWrReq = 1'b0;
  endtask

  task automatic popWord(input logic cpl);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL pop_sb_empty observed=0 expected=1");
    end else begin
      check("head", TxRpFifoData, sb[0]);
      void'(sb.pop_front());
    end
    TxRpFifoRdReq = 1'b1;
    RxCplDone     = cpl;
    tick();
    TxRpFifoRdReq = 1'b0;
    RxCplDone     = 1'b0;
  endtask

  task automatic cplPulse();
    RxCplDone = 1'b1;
    tick();
    RxCplDone = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, "_full"}, RxRpFifoFull, 0);
    check({tag, "_tlprdy"}, RpTLPReady, 0);
    check({tag, "_rdprog"}, RxRdInProgress, 0);
    check({tag, "_ovf"}, OverflowErr, 0);
    check({tag, "_mbreq"}, A2PMbWrReq, 0);
    check({tag, "_mbaddr"}, A2PMbWrAddr, 0);
    check({tag, "_irq"}, PCIeIrqEna, 0);
    check({tag, "_mstr"}, MasterEnable, 0);
  endtask

  initial begin
    logic [130:0] w;
    #12;
    checkResetState("rst0");
    rst = 1'b0;
    tick();

    // Bus-master enable is a single register delay
    CfgBusMstrEn = 1'b1;
    #1;
    check("mstr_before", MasterEnable, 0);
    tick();
    check("mstr_after", MasterEnable, 1);

    // Three-word TLP
    pushWord(mkWord(1, 0, 32'h6000_0001, 32'h0000_1050, 32'h1111_1111));
    pushWord(mkWord(0, 0, 32'h0, 32'h2222_2222, 32'h3333_3333));
    check("tlprdy_mid", RpTLPReady, 0);
    pushWord(mkWord(0, 1, 32'h0, 32'h4444_4444, 32'h5555_5555));
    check("tlprdy_eop", RpTLPReady, 1);
    check("mb_4dw_none", A2PMbWrReq, 0);
    popWord(0);
    popWord(0);
    check("tlprdy_before_eop_pop", RpTLPReady, 1);
    popWord(0);
    check("tlprdy_drained", RpTLPReady, 0);
    check("rdprog_mwr_pop", RxRdInProgress, 0);

    // Fill to full, overflow with a would-be mailbox write, push+pop while full
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("full_at_31", RxRpFifoFull, 0);
      pushWord(mkWord(0, 0, 32'h0, 32'h100 + i, 32'hA000_0000 + i));
    end
    check("full_at_32", RxRpFifoFull, 1);
    check("ovf_not_yet", OverflowErr, 0);
    pushWord(mkWord(1, 1, 32'h4000_0001, 32'h0000_1050, 32'hDEAD_BEEF));
    check("ovf_set", OverflowErr, 1);
    check("mb_dropped", A2PMbWrReq, 0);
    check("irq_dropped", PCIeIrqEna, 0);
    check("tlprdy_dropped", RpTLPReady, 0);
    for (int i = 0; i < 2; i++) begin
      w = mkWord(0, 0, 32'h0, 32'h200 + i, 32'hB000_0000 + i);
      check("pp_head", TxRpFifoData, sb[0]);
      void'(sb.pop_front());
      sb.push_back(w);
      RxRpFifoWrData = w;
      RxRpFifoWrReq  = 1'b1;
      TxRpFifoRdReq  = 1'b1;
      tick();
      RxRpFifoWrReq  = 1'b0;
      TxRpFifoRdReq  = 1'b0;
      check("pp_full", RxRpFifoFull, 1);
    end
    while (sb.size() > 0) popWord(0);
    check("drain_full", RxRpFifoFull, 0);
    check("ovf_sticky", OverflowErr, 1);

    // Mailbox snooping
    pushWord(mkWord(1, 1, 32'h4000_0001, 32'h0000_1050, 32'h0000_00FF));
    check("mb_req", A2PMbWrReq, 1);
    check("mb_addr", A2PMbWrAddr, 12'h050);
    check("mb_irq", PCIeIrqEna, 32'h0000_00FF);
    tick();
    check("mb_req_once", A2PMbWrReq, 0);
    check("mb_addr_hold", A2PMbWrAddr, 12'h050);
    pushWord(mkWord(1, 1, 32'h4000_0001, 32'h0000_2050, 32'h0000_0011));
    check("mb_outside", A2PMbWrReq, 0);
    pushWord(mkWord(1, 1, 32'h6000_0001, 32'h0000_1050, 32'h0000_0055));
    check("mb_4dw", A2PMbWrReq, 0);
    check("irq_4dw", PCIeIrqEna, 32'h0000_00FF);
    pushWord(mkWord(1, 1, 32'h4000_0001, 32'h0000_1010, 32'h0000_0077));
    check("mb_other_req", A2PMbWrReq, 1);
    check("mb_other_addr", A2PMbWrAddr, 12'h010);
    check("mb_other_irq", PCIeIrqEna, 32'h0000_00FF);
    while (sb.size() > 0) popWord(0);
    check("rdprog_after_mwr", RxRdInProgress, 0);

    // Outstanding-read tracking
    pushWord(mkWord(1, 1, 32'h0000_0001, 32'h10, 32'h0));
    pushWord(mkWord(1, 1, 32'h2000_0001, 32'h20, 32'h0));
    pushWord(mkWord(1, 1, 32'h0000_0001, 32'h30, 32'h0));
    popWord(0);
    check("rd_cnt1", RxRdInProgress, 1);
    popWord(0);
    popWord(1);
    check("rd_cnt2", RxRdInProgress, 1);
    cplPulse();
    check("rd_cnt1b", RxRdInProgress, 1);
    cplPulse();
    check("rd_cnt0", RxRdInProgress, 0);
    cplPulse();
    check("rd_floor", RxRdInProgress, 0);
    for (int i = 0; i < 9; i++) pushWord(mkWord(1, 1, 32'h0000_0001, 32'h40 + i, 32'h0));
    while (sb.size() > 0) popWord(0);
    for (int i = 0; i < 7; i++) cplPulse();
    check("rd_sat_7", RxRdInProgress, 1);
    cplPulse();
    check("rd_sat_8", RxRdInProgress, 0);

    // Reset with five words buffered mid-TLP
    pushWord(mkWord(1, 0, 32'h6000_0001, 32'h50, 32'h1));
    pushWord(mkWord(0, 1, 32'h0, 32'h51, 32'h2));
    pushWord(mkWord(1, 0, 32'h0000_0001, 32'h52, 32'h3));
    pushWord(mkWord(0, 0, 32'h0, 32'h53, 32'h4));
    pushWord(mkWord(0, 0, 32'h0, 32'h54, 32'h5));
    popWord(0);
    pushWord(mkWord(1, 1, 32'h4000_0001, 32'h0000_1050, 32'h0000_ABCD));
    check("pre_rst_tlprdy", RpTLPReady, 1);
    check("pre_rst_irq", PCIeIrqEna, 32'h0000_ABCD);
    #2;
    rst = 1'b1;
    #1;
    checkResetState("rst_mid");
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_tlprdy", RpTLPReady, 0);
    check("post_rst_full", RxRpFifoFull, 0);
    check("post_rst_rdprog", RxRdInProgress, 0);
    pushWord(mkWord(0, 1, 32'h0, 32'h60, 32'hCAFE_0001));
    popWord(0);
    check("post_rst_empty_tlprdy", RpTLPReady, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
